exu_muldiv: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the RV64M/RV32M extension.
- Sits beside the single-cycle execute datapath and receives decoded M-ops with their operands.
- Returns one XLEN result per operation over a valid/ready handshake.
- Lets the core stall on long-latency arithmetic instead of building combinational multipliers and dividers.

---
 rtl/exu_muldiv_pkg.sv | 60 ++++++
 rtl/exu_muldiv_iter_unit.sv | 80 ++++++++
 rtl/exu_muldiv.sv | 164 ++++++++++++++++
 tb/tb_exu_muldiv.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/exu_muldiv_pkg.sv
// Shared M-extension definitions: op codes, FSM encoding and the op decode helper
// used by the iterative multiply/divide unit.
package exu_muldiv_pkg;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd12;
  localparam logic [3:0] OP_DIVUW  = 4'd13;
  localparam logic [3:0] OP_REMW   = 4'd14;
  localparam logic [3:0] OP_REMUW  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_e;

  typedef struct packed {
    logic legal;
    logic is_div;
    logic is_rem;
    logic is_w;
    logic hi;
    logic sgn1;
    logic sgn2;
  } dec_t;

  // sgn1/sgn2 mark which operands are interpreted as two's complement.
  function automatic dec_t decode(input logic [3:0] op, input logic w_en);
    dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_MUL:    d.hi = 1'b0;
      OP_MULH:   begin d.hi = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      OP_MULHSU: begin d.hi = 1'b1; d.sgn1 = 1'b1; end
      OP_MULHU:  d.hi = 1'b1;
      OP_DIV:    begin d.is_div = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      OP_DIVU:   d.is_div = 1'b1;
      OP_REM:    begin d.is_div = 1'b1; d.is_rem = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; end
      OP_REMU:   begin d.is_div = 1'b1; d.is_rem = 1'b1; end
      OP_MULW:   begin d.is_w = 1'b1; d.legal = w_en; end
      OP_DIVW:   begin d.is_div = 1'b1; d.is_w = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; d.legal = w_en; end
      OP_DIVUW:  begin d.is_div = 1'b1; d.is_w = 1'b1; d.legal = w_en; end
      OP_REMW:   begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; d.sgn1 = 1'b1; d.sgn2 = 1'b1; d.legal = w_en; end
      OP_REMUW:  begin d.is_div = 1'b1; d.is_rem = 1'b1; d.is_w = 1'b1; d.legal = w_en; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exu_muldiv_iter_unit.sv
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// unsigned magnitudes; the top level handles signs and result selection.
module mdu_iter_unit
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              div_i,
  input  logic              w_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              step_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quo_o,
  output logic [XLEN-1:0]   rem_o
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [XLEN:0]     tmp, diff;

  always_comb begin
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    div_d = div_q;
    tmp   = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    diff  = tmp - {1'b0, opb_q[XLEN-1:0]};
    if (start_i) begin
      // mul: opa = multiplier, opb = multiplicand; div: opa = dividend, opb = divisor
      acc_d = '0;
      div_d = div_i;
      opa_d = div_i ? a_i : b_i;
      opb_d = {{XLEN{1'b0}}, (div_i ? b_i : a_i)};
      cnt_d = w_i ? CNT_W'(32) : CNT_W'(XLEN);
    end else if (step_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        acc_d = {{XLEN{1'b0}}, (diff[XLEN] ? tmp[XLEN-1:0] : diff[XLEN-1:0])};
        opa_d = {opa_q[XLEN-2:0], ~diff[XLEN]};
      end else begin
        acc_d = opa_q[0] ? acc_q + opb_q : acc_q;
        opa_d = opa_q >> 1;
        opb_d = opb_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign prod_o = acc_q;
  assign quo_o  = opa_q;
  assign rem_o  = acc_q[XLEN-1:0];

endmodule

// File: rtl/exu_muldiv.sv
// Iterative RV64M/RV32M multiply/divide unit: owns the handshake FSM, special-case
// results (illegal op, divide by zero, signed overflow) and sign correction.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit W_OPS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_e            state_q, state_d;
  logic              is_div_q, is_div_d, is_rem_q, is_rem_d;
  logic              is_w_q, is_w_d, hi_q, hi_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   result_q, result_d;

  dec_t              dec;
  logic [XLEN-1:0]   a_w, a_ext, b_ext, a_abs, b_abs, iter_a, spec_res;
  logic              a_neg, b_neg, b_zero, ovf, special, start;
  logic              iter_last;
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0]   quo, rem, mul_r, div_r, fix_r, fix_res;

  always_comb begin
    dec   = decode(op, W_OPS);
    a_w   = sext32(src1[31:0]);
    a_ext = src1;
    b_ext = src2;
    if (dec.is_w) begin
      a_ext = dec.sgn1 ? a_w : XLEN'(src1[31:0]);
      b_ext = dec.sgn2 ? sext32(src2[31:0]) : XLEN'(src2[31:0]);
    end
    a_neg  = dec.sgn1 & a_ext[XLEN-1];
    b_neg  = dec.sgn2 & b_ext[XLEN-1];
    a_abs  = neg_if(a_ext, a_neg);
    b_abs  = neg_if(b_ext, b_neg);
    b_zero = (b_ext == '0);
    ovf    = dec.sgn1 & (b_ext == '1) &
             (dec.is_w ? (src1[31:0] == 32'h8000_0000) : (src1 == MIN_NEG));
    special  = ~dec.legal | (dec.is_div & (b_zero | ovf));
    spec_res = '0;
    if (dec.legal & dec.is_div) begin
      if (b_zero)   spec_res = dec.is_rem ? (dec.is_w ? a_w : src1) : '1;
      else if (ovf) spec_res = dec.is_rem ? '0 : (dec.is_w ? a_w : src1);
    end
    // a 32-bit dividend must sit at the top of the shift register so 32 steps consume it
    iter_a = (dec.is_div & dec.is_w) ? (a_abs << (XLEN - 32)) : a_abs;
  end

  mdu_iter_unit #(.XLEN(XLEN)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .div_i   (dec.is_div),
    .w_i     (dec.is_w),
    .a_i     (iter_a),
    .b_i     (b_abs),
    .step_i  (state_q == S_BUSY),
    .last_o  (iter_last),
    .prod_o  (prod),
    .quo_o   (quo),
    .rem_o   (rem)
  );

  always_comb begin
    prod_c  = neg_if2(prod, qneg_q);
    mul_r   = hi_q ? prod_c[2*XLEN-1:XLEN] : prod_c[XLEN-1:0];
    div_r   = is_rem_q ? neg_if(rem, rneg_q) : neg_if(quo, qneg_q);
    fix_r   = is_div_q ? div_r : mul_r;
    fix_res = is_w_q ? sext32(fix_r[31:0]) : fix_r;
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    is_rem_d = is_rem_q;
    is_w_d   = is_w_q;
    hi_d     = hi_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          is_div_d = dec.is_div;
          is_rem_d = dec.is_rem;
          is_w_d   = dec.is_w;
          hi_d     = dec.hi;
          qneg_d   = a_neg ^ b_neg;
          rneg_d   = a_neg;
          if (special) begin
            result_d = spec_res;
            state_d  = S_DONE;
          end else begin
            start   = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: if (iter_last) state_d = S_FIX;
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    result    = result_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      is_rem_q <= 1'b0;
      is_w_q   <= 1'b0;
      hi_q     <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      is_rem_q <= is_rem_d;
      is_w_q   <= is_w_d;
      hi_q     <= hi_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Scoreboard bench for exu_muldiv at XLEN=64: driver queues expected results and
// latencies, a negedge monitor checks them whenever the unit presents a result.
module tb_exu_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [63:0] res;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic ov_prev = 1'b0;

  exu_muldiv #(.XLEN(64), .W_OPS(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Latency counts posedges from the accepting edge (inclusive) to the edge that raised out_valid.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid === 1'b1 && !ov_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid got 1 want 0");
        end else begin
          chk({sb[0].name, "_lat"}, 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0 && sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk(mon_e.name, result, mon_e.res);
      end
    end
    ov_prev = (out_valid === 1'b1);
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input string name, input logic [3:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input int lat,
                       input bit track);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_accept got in_ready=%b want 1", name, in_ready);
      return;
    end
    in_valid = 1'b1;
    op       = o;
    src1     = a;
    src2     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (track) sb.push_back('{name: name, res: res, lat: lat, acc_cyc: cyc});
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got pending=%0d want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_op(input string name, input logic [3:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input int lat);
    issue(name, o, a, b, res, lat, 1'b1);
    wait_done(name);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    do_op("mul",    4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    do_op("mulhu",  4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    do_op("mulh",   4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66);
    do_op("mulhsu", 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op("div0",   4'd4, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("rem0",   4'd6, 64'd42, 64'd0, 64'd42, 1);
    do_op("divovf", 4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    do_op("removf", 4'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    do_op("div_neg", 4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    do_op("rem_neg", 4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op("divw",   4'd12, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
    do_op("remw",   4'd14, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    do_op("divuw",  4'd13, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 34);
    do_op("remuw",  4'd15, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'd1, 34);
    do_op("remuw0", 4'd15, 64'hFFFF_FFFF_8000_0001, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
    do_op("mulw",   4'd8, 64'hFFFF_FFFF_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 34);
    do_op("illegal", 4'd9, 64'd5, 64'd6, 64'd0, 1);

    // Backpressure: hold the result in DONE for several cycles.
    out_ready = 1'b0;
    issue("bp_divu", 4'd5, 64'd100, 64'd7, 64'd14, 66, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result", result, 64'd14);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done("bp_divu");

    // Flush in the tenth BUSY cycle drops the op.
    issue("flush_mul", 4'd0, 64'd123, 64'd456, 64'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    repeat (80) @(posedge clk);
    #1;
    do_op("mul_after_flush", 4'd0, 64'd3, 64'd5, 64'd15, 66);

    // Reset while an op is iterating.
    issue("rst_div", 4'd4, 64'd1000, 64'd3, 64'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    do_op("divu_after_rst", 4'd5, 64'd1000, 64'd3, 64'd333, 66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
